// File: rtl/cluster_pkg.sv
// Shared definitions for the cluster serializer: cluster geometry, link word
// layout, FSM encoding and the header word builder.
package cluster_pkg;
  localparam int MXADRBITS  = 11;
  localparam int MXCNTBITS  = 3;
  localparam int MXCLUSTERS = 8;
  localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;

  localparam int LINK_W   = 14;
  localparam int IDX_W    = $clog2(MXCLUSTERS);
  localparam int NCLUST_W = IDX_W + 1;

  localparam int HDR_SEQ_MSB    = 13;
  localparam int HDR_SEQ_LSB    = 4;
  localparam int HDR_NCLUST_MSB = 3;
  localparam int HDR_NCLUST_LSB = 0;
  localparam int SEQ_W          = HDR_SEQ_MSB - HDR_SEQ_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [LINK_W-1:0] hdr_word(input logic [SEQ_W-1:0]    seq,
                                                 input logic [NCLUST_W-1:0] nclust);
    logic [LINK_W-1:0] w;
    w = '0;
    w[HDR_SEQ_MSB:HDR_SEQ_LSB]       = seq;
    w[HDR_NCLUST_MSB:HDR_NCLUST_LSB] = nclust;
    return w;
  endfunction
endpackage

// File: rtl/cluster_valid_count.sv
// Counts the leading run of valid cluster slots starting at slot 0; anything
// after the first invalid slot is ignored.
module cluster_valid_count
  import cluster_pkg::*;
(
  input  logic [MXCLUSTERS*MXADRBITS-1:0] i_adr,
  output logic [NCLUST_W-1:0]             o_nclust
);

  logic w_run;

  always_comb begin
    o_nclust = '0;
    w_run    = 1'b1;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      if (w_run && (i_adr[i*MXADRBITS +: MXADRBITS] != INVALID_ADR))
        o_nclust = o_nclust + NCLUST_W'(1);
      else
        w_run = 1'b0;
    end
  end

endmodule

// File: rtl/cluster_serializer.sv
// Captures one sorted cluster set per load and streams it as a header word
// followed by one word per leading valid cluster on a valid/ready link.
module cluster_serializer
  import cluster_pkg::*;
(
  input  logic                            clock4x,
  input  logic                            reset_n,
  input  logic                            load,
  output logic                            in_ready,
  input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
  input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
  output logic [LINK_W-1:0]               tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            tx_sof,
  output logic                            tx_eof,
  output logic [7:0]                      overflow_cnt
);

  state_t                r_state;
  logic [MXADRBITS-1:0]  r_adr [MXCLUSTERS];
  logic [MXCNTBITS-1:0]  r_cnt [MXCLUSTERS];
  logic [NCLUST_W-1:0]   r_nclust;
  logic [IDX_W-1:0]      r_idx;
  logic [SEQ_W-1:0]      r_seq;
  logic [7:0]            r_ovf;
  logic [LINK_W-1:0]     r_tx_data;
  logic                  r_tx_valid;
  logic                  r_sof;
  logic                  r_eof;
  logic                  r_in_ready;

  logic [NCLUST_W-1:0]   w_nclust;
  logic                  w_take;
  logic                  w_accept;
  logic [IDX_W-1:0]      w_next_idx;
  logic [LINK_W-1:0]     w_next_word;
  logic                  w_next_eof;

  cluster_valid_count u_valid_count (
    .i_adr    (adr_in),
    .o_nclust (w_nclust)
  );

  assign w_take   = load && r_in_ready;
  assign w_accept = r_tx_valid && tx_ready;

  // Word that follows the current one: slot 0 after the header, else idx+1.
  always_comb begin
    w_next_idx  = (r_state == ST_HDR) ? '0 : r_idx + IDX_W'(1);
    w_next_word = {r_adr[w_next_idx], r_cnt[w_next_idx]};
    w_next_eof  = ({1'b0, w_next_idx} == (r_nclust - NCLUST_W'(1)));
  end

  // Cluster payload is only ever read after a capture, so it carries no reset.
  always_ff @(posedge clock4x) begin
    if (w_take) begin
      for (int i = 0; i < MXCLUSTERS; i++) begin
        r_adr[i] <= adr_in[i*MXADRBITS +: MXADRBITS];
        r_cnt[i] <= cnt_in[i*MXCNTBITS +: MXCNTBITS];
      end
      r_nclust <= w_nclust;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_seq      <= '0;
      r_ovf      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      if (load && !r_in_ready && (r_ovf != 8'hFF))
        r_ovf <= r_ovf + 8'd1;

      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_take) begin
            r_state    <= ST_HDR;
            r_in_ready <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= hdr_word(r_seq, w_nclust);
            r_sof      <= 1'b1;
            r_eof      <= (w_nclust == '0);
          end
        end
        ST_HDR, ST_DATA: begin
          if (w_accept) begin
            if (r_eof) begin
              r_state    <= ST_IDLE;
              r_seq      <= r_seq + SEQ_W'(1);
              r_tx_valid <= 1'b0;
              r_sof      <= 1'b0;
              r_eof      <= 1'b0;
              r_in_ready <= 1'b1;
            end else begin
              r_state   <= ST_DATA;
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_word;
              r_sof     <= 1'b0;
              r_eof     <= w_next_eof;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign tx_sof       = r_sof;
  assign tx_eof       = r_eof;
  assign overflow_cnt = r_ovf;

endmodule

// File: doc/cluster_serializer.md
Name: cluster_serializer

Overview:
- Transmit-side consumer of the sorted cluster list from the cluster sorter/merger: 8 clusters (11-bit address, 3-bit count) per load, address-ascending, invalid entries carrying address 0x7FF.
- Captures one cluster set per load, then streams it as one frame on a 14-bit link with valid/ready backpressure: a header word followed by one word per valid cluster.
- Sits between the cluster packer output and the link/FIFO interface.

Parameters:
- MXADRBITS, 11, cluster address width.
- MXCNTBITS, 3, cluster size-count width.
- MXCLUSTERS, 8, clusters per input set.
- INVALID_ADR, 11'h7FF, address value marking an empty cluster slot.

Ports:
- clock4x  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  input set valid; accepted only when in_ready=1.
- in_ready  out  1  high when the block can capture a new set.
- adr_in  in  MXCLUSTERS*MXADRBITS  cluster i address at bits [i*11 +: 11]; slot 0 is lowest.
- cnt_in  in  MXCLUSTERS*MXCNTBITS  cluster i count at bits [i*3 +: 3].
- tx_data  out  14  header or cluster word.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the word when tx_valid&tx_ready.
- tx_sof  out  1  current word is the header.
- tx_eof  out  1  current word is the last word of the frame.
- overflow_cnt  out  8  loads dropped while busy; saturates at 255.

Behaviour:
- Reset values: in_ready=0 while reset_n=0, then 1. tx_valid=0, tx_sof=0, tx_eof=0, tx_data=0, overflow_cnt=0. Frame sequence counter seq=0. State=IDLE.
- Reset asserted mid-frame aborts the frame immediately; no resume.
- States: IDLE, HDR, DATA.
- IDLE:
  - in_ready=1.
  - On load: register all 8 address/count pairs and nclust, then go to HDR.
  - nclust = number of leading slots (from slot 0) with adr != INVALID_ADR, range 0..8.
  - Slots after the first invalid slot are ignored, even if they hold a valid address.
- Latency: load accepted at edge t gives header on tx_valid after edge t (visible in cycle t+1).
- HDR:
  - tx_data={seq[9:0], nclust[3:0]}, tx_sof=1, tx_eof=(nclust==0).
  - On accept: if nclust==0, go to IDLE and increment seq; else go to DATA with index=0.
- DATA:
  - tx_data={adr[index], cnt[index]}, tx_eof=(index==nclust-1).
  - On accept: index+1; after the eof word, go to IDLE and increment seq.
- seq is 10 bits and wraps 1023->0.
- Handshake rules:
  - Word held stable (data and flags) while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without an accept.
  - One word per cycle at most; back-to-back when tx_ready=1 stays high.
- Frame length is nclust+1 words. A full set of 8 clusters takes 9 cycles with no backpressure.
- in_ready=0 in HDR/DATA. It returns to 1 the cycle after the final accept; there is no same-cycle reload.
- load while in_ready=0: set is dropped and overflow_cnt increments, saturating at 255 (no wrap).
- load is ignored during reset.
- Input data is sampled only on the accepting edge; later changes to adr_in/cnt_in have no effect on the frame.

Decomposition:
- Shared package (cluster_pkg) holds:
  - MXADRBITS, MXCNTBITS, MXCLUSTERS, INVALID_ADR.
  - Link word width 14.
  - Header field positions (SEQ 13:4, NCLUST 3:0).
  - State encoding.
- One sub-module: cluster_valid_count. It is combinational: takes 8 addresses and returns the leading-valid count nclust[3:0]. The top holds the FSM, capture registers, seq and overflow counters.

Test Plan:
- Set with adr=5,20,100,7FF,...(rest 7FF), cnt=1,2,3; tx_ready=1 -> header 0x0003 with sof, then words {5,1},{20,2},{100,3}; eof on the third; in_ready back to 1 after it.
- All 8 slots 7FF -> single word 0x0000 with sof=1 and eof=1; the next frame's header carries seq=1.
- 8 valid clusters; tx_ready toggled 1,0,0,1,... -> 9 words in order, each held stable while stalled; no duplicates or drops.
- load pulsed on every cycle during a frame -> frame unaffected; overflow_cnt counts each pulse. After 300 drops overflow_cnt=255.
- Slot 0 valid, slot 1 7FF, slot 2 valid -> nclust=1; only the slot 0 word is sent.
- reset_n low during DATA word 2 -> outputs reset immediately; after release, a new load produces a header with seq=0.
- 1024 empty frames -> seq wraps to 0 on frame 1025.
